// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer: FSM state codes,
// interrupt cause codes and the latched return type.
package trap_pkg;

    localparam int EXC_CODE_W = 5;
    localparam int INSTR_W    = 30;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_SIGNAL   = 2'd1;
    localparam state_t ST_FLUSH    = 2'd2;
    localparam state_t ST_REDIRECT = 2'd3;

    localparam logic [EXC_CODE_W-1:0] CODE_MEI = 5'd11;
    localparam logic [EXC_CODE_W-1:0] CODE_MTI = 5'd7;
    localparam logic [EXC_CODE_W-1:0] CODE_SEI = 5'd9;
    localparam logic [EXC_CODE_W-1:0] CODE_STI = 5'd5;

    typedef enum logic [1:0] {
        RET_NONE = 2'd0,
        RET_MRET = 2'd1,
        RET_SRET = 2'd2
    } ret_e;

endpackage

// File: rtl/irq_sync.sv
// Flop-chain synchroniser for one asynchronous interrupt line.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) chain <= '0;
        else       chain <= {chain[SYNC_STAGES-2:0], d};
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer between execute and the CSR file: picks one event, strobes the
// register file, flushes, then redirects fetch. Build option: TRAP_VECTORED_EN.
//
// state    | meaning
// IDLE     | waiting for an event while stall is low
// SIGNAL   | one-cycle strobe of the latched trap/return to the register file
// FLUSH    | pipeline kill, strobes quiet
// REDIRECT | one-cycle fetch redirect, target sampled now
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  stall,
    input  logic                  exc_valid,
    input  logic [EXC_CODE_W-1:0] exc_code,
    input  logic [XLEN-1:0]       exc_pc,
    input  logic [INSTR_W-1:0]    exc_instr,
    input  logic                  mret_valid,
    input  logic                  sret_valid,
    input  logic [XLEN-1:0]       irq_pc,
    input  logic                  ext_irq_m,
    input  logic                  ext_irq_s,
    input  logic                  timer_irq_m,
    input  logic                  timer_irq_s,
    input  logic                  m_eie,
    input  logic                  m_tie,
    input  logic                  s_eie,
    input  logic                  s_tie,
    input  logic [XLEN-1:0]       mtvec_in,
    input  logic [XLEN-1:0]       mepc_in,
    input  logic [XLEN-1:0]       sepc_in,
    output logic                  exception_pending,
    output logic [XLEN-1:0]       m_cause,
    output logic [XLEN-1:0]       pc_exc,
    output logic [INSTR_W-1:0]    instruction_word,
    output logic                  m_ret,
    output logic                  s_ret,
    output logic                  m_interrupt,
    output logic                  s_interrupt,
    output logic                  flush,
    output logic                  stall_req,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc
);

    logic ext_m_sync, ext_s_sync, tmr_m_sync, tmr_s_sync;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext_m (
        .clk(clk), .nrst(nrst), .d(ext_irq_m),   .q(ext_m_sync));
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext_s (
        .clk(clk), .nrst(nrst), .d(ext_irq_s),   .q(ext_s_sync));
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tmr_m (
        .clk(clk), .nrst(nrst), .d(timer_irq_m), .q(tmr_m_sync));
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tmr_s (
        .clk(clk), .nrst(nrst), .d(timer_irq_s), .q(tmr_s_sync));

    assign m_interrupt = ext_m_sync;
    assign s_interrupt = ext_s_sync;

    state_t              state;
    logic [XLEN-1:0]     hold_cause;
    logic [XLEN-1:0]     hold_pc;
    logic [INSTR_W-1:0]  hold_instr;
    ret_e                hold_ret;

    logic                take;
    logic                is_irq;
    logic [EXC_CODE_W-1:0] irq_code;
    logic [XLEN-1:0]     sel_cause;
    logic [XLEN-1:0]     sel_pc;
    logic [INSTR_W-1:0]  sel_instr;
    ret_e                sel_ret;
    logic                accept;
    logic [XLEN-1:0]     target;

    // Priority select; returns latch zero cause/pc so SIGNAL drives 0 for them.
    always_comb begin
        take      = 1'b1;
        is_irq    = 1'b0;
        irq_code  = '0;
        sel_cause = '0;
        sel_pc    = '0;
        sel_instr = '0;
        sel_ret   = RET_NONE;
        if (exc_valid) begin
            sel_cause = XLEN'(exc_code);
            sel_pc    = exc_pc;
            sel_instr = exc_instr;
        end else if (mret_valid) begin
            sel_ret = RET_MRET;
        end else if (sret_valid) begin
            sel_ret = RET_SRET;
        end else if (ext_m_sync && m_eie) begin
            is_irq   = 1'b1;
            irq_code = CODE_MEI;
        end else if (tmr_m_sync && m_tie) begin
            is_irq   = 1'b1;
            irq_code = CODE_MTI;
        end else if (ext_s_sync && s_eie) begin
            is_irq   = 1'b1;
            irq_code = CODE_SEI;
        end else if (tmr_s_sync && s_tie) begin
            is_irq   = 1'b1;
            irq_code = CODE_STI;
        end else begin
            take = 1'b0;
        end
        if (is_irq) begin
            sel_cause = {1'b1, (XLEN-1)'(irq_code)};
            sel_pc    = irq_pc;
        end
    end

    assign accept = (state == ST_IDLE) && !stall && take;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            hold_cause <= '0;
            hold_pc    <= '0;
            hold_instr <= '0;
            hold_ret   <= RET_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_SIGNAL;
                        hold_cause <= sel_cause;
                        hold_pc    <= sel_pc;
                        hold_instr <= sel_instr;
                        hold_ret   <= sel_ret;
                    end
                end
                ST_SIGNAL: state <= ST_FLUSH;
                ST_FLUSH:  state <= ST_REDIRECT;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Target read live in REDIRECT so CSR writes made at the SIGNAL edge land.
    always_comb begin
        target = mtvec_in;
        case (hold_ret)
            RET_MRET: target = mepc_in;
            RET_SRET: target = sepc_in;
            default: begin
`ifdef TRAP_VECTORED_EN
                if (hold_cause[XLEN-1])
                    target = mtvec_in + (XLEN'(hold_cause[EXC_CODE_W-1:0]) << 2);
`endif
            end
        endcase
    end

    always_comb begin
        exception_pending = 1'b0;
        m_cause           = '0;
        pc_exc            = '0;
        instruction_word  = '0;
        m_ret             = 1'b0;
        s_ret             = 1'b0;
        flush             = 1'b0;
        stall_req         = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        case (state)
            ST_SIGNAL: begin
                exception_pending = 1'b1;
                m_cause           = hold_cause;
                pc_exc            = hold_pc;
                instruction_word  = hold_instr;
                m_ret             = (hold_ret == RET_MRET);
                s_ret             = (hold_ret == RET_SRET);
                flush             = 1'b1;
                stall_req         = 1'b1;
            end
            ST_FLUSH: begin
                flush     = 1'b1;
                stall_req = 1'b1;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                stall_req      = 1'b1;
                redirect_pc    = target & ~XLEN'(3);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized events
// checked against a priority/latency reference model.
module tb_trap_ctrl;

    localparam int XLEN = 32;
    localparam int SS   = 2;

    logic            clk = 1'b0;
    logic            nrst;
    logic            stall;
    logic            exc_valid;
    logic [4:0]      exc_code;
    logic [31:0]     exc_pc;
    logic [29:0]     exc_instr;
    logic            mret_valid, sret_valid;
    logic [31:0]     irq_pc;
    logic            ext_irq_m, ext_irq_s, timer_irq_m, timer_irq_s;
    logic            m_eie, m_tie, s_eie, s_tie;
    logic [31:0]     mtvec_in, mepc_in, sepc_in;
    logic            exception_pending;
    logic [31:0]     m_cause, pc_exc;
    logic [29:0]     instruction_word;
    logic            m_ret, s_ret, m_interrupt, s_interrupt;
    logic            flush, stall_req, redirect_valid;
    logic [31:0]     redirect_pc;
    logic [5:0]      ctl;

    int checks   = 0;
    int failures = 0;

    assign ctl = {exception_pending, m_ret, s_ret, flush, stall_req, redirect_valid};

    trap_ctrl #(.XLEN(XLEN), .SYNC_STAGES(SS)) dut (
        .clk(clk), .nrst(nrst), .stall(stall),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_instr(exc_instr),
        .mret_valid(mret_valid), .sret_valid(sret_valid), .irq_pc(irq_pc),
        .ext_irq_m(ext_irq_m), .ext_irq_s(ext_irq_s),
        .timer_irq_m(timer_irq_m), .timer_irq_s(timer_irq_s),
        .m_eie(m_eie), .m_tie(m_tie), .s_eie(s_eie), .s_tie(s_tie),
        .mtvec_in(mtvec_in), .mepc_in(mepc_in), .sepc_in(sepc_in),
        .exception_pending(exception_pending), .m_cause(m_cause), .pc_exc(pc_exc),
        .instruction_word(instruction_word), .m_ret(m_ret), .s_ret(s_ret),
        .m_interrupt(m_interrupt), .s_interrupt(s_interrupt),
        .flush(flush), .stall_req(stall_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        stall = 1'b0; exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_instr = '0;
        mret_valid = 1'b0; sret_valid = 1'b0; irq_pc = '0;
        ext_irq_m = 1'b0; ext_irq_s = 1'b0; timer_irq_m = 1'b0; timer_irq_s = 1'b0;
        m_eie = 1'b0; m_tie = 1'b0; s_eie = 1'b0; s_tie = 1'b0;
        mtvec_in = '0; mepc_in = '0; sepc_in = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        nrst = 1'b0;
        exc_valid = 1'b1; ext_irq_m = 1'b1; ext_irq_s = 1'b1; m_eie = 1'b1;
        neg(3);
        checks++;
        if (ctl !== 6'b0) begin
            failures++; $display("FAIL reset_ctl: got %b want 000000", ctl);
        end
        checks++;
        if ({m_cause, pc_exc, redirect_pc} !== 96'b0 || instruction_word !== 30'b0) begin
            failures++; $display("FAIL reset_data: cause=%h pc=%h rpc=%h instr=%h want 0",
                                 m_cause, pc_exc, redirect_pc, instruction_word);
        end
        checks++;
        if ({m_interrupt, s_interrupt} !== 2'b00) begin
            failures++; $display("FAIL reset_sync: got %b want 00", {m_interrupt, s_interrupt});
        end
        clear_inputs();
        nrst = 1'b1;
        neg(2);
    endtask

    task automatic test_sync_latency();
        stall = 1'b1;
        ext_irq_m = 1'b1; ext_irq_s = 1'b1;
        neg(SS - 1);
        checks++;
        if ({m_interrupt, s_interrupt} !== 2'b00) begin
            failures++; $display("FAIL sync_early: got %b want 00", {m_interrupt, s_interrupt});
        end
        neg(1);
        checks++;
        if ({m_interrupt, s_interrupt} !== 2'b11) begin
            failures++; $display("FAIL sync_level: got %b want 11", {m_interrupt, s_interrupt});
        end
        ext_irq_m = 1'b0; ext_irq_s = 1'b0;
        neg(SS);
        checks++;
        if ({m_interrupt, s_interrupt} !== 2'b00) begin
            failures++; $display("FAIL sync_fall: got %b want 00", {m_interrupt, s_interrupt});
        end
        stall = 1'b0;
        neg(1);
    endtask

    task automatic test_exception();
        exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h100; exc_instr = 30'h3FFFFFFF;
        mtvec_in = 32'h200;
        neg(1);
        exc_valid = 1'b0;
        checks++;
        if (ctl !== 6'b100110 || m_cause !== 32'h2 || pc_exc !== 32'h100
            || instruction_word !== 30'h3FFFFFFF) begin
            failures++; $display("FAIL exc_signal: ctl=%b cause=%h pc=%h instr=%h want 100110/2/100/3fffffff",
                                 ctl, m_cause, pc_exc, instruction_word);
        end
        neg(1);
        checks++;
        if (ctl !== 6'b000110) begin
            failures++; $display("FAIL exc_flush: ctl=%b want 000110", ctl);
        end
        neg(1);
        checks++;
        if (ctl !== 6'b000011 || redirect_pc !== 32'h200) begin
            failures++; $display("FAIL exc_redirect: ctl=%b rpc=%h want 000011/200", ctl, redirect_pc);
        end
        neg(1);
        checks++;
        if (ctl !== 6'b0) begin
            failures++; $display("FAIL exc_idle: ctl=%b want 000000", ctl);
        end
    endtask

    task automatic test_mret();
        mret_valid = 1'b1; mepc_in = 32'h80; mtvec_in = 32'h200;
        neg(1);
        mret_valid = 1'b0;
        checks++;
        if (ctl !== 6'b110110 || m_cause !== 32'h0 || pc_exc !== 32'h0) begin
            failures++; $display("FAIL mret_signal: ctl=%b cause=%h pc=%h want 110110/0/0",
                                 ctl, m_cause, pc_exc);
        end
        neg(2);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin
            failures++; $display("FAIL mret_redirect: rv=%b rpc=%h want 1/80", redirect_valid, redirect_pc);
        end
        neg(1);
    endtask

    task automatic test_irq_priority();
        int n;
        logic [31:0] want;
        irq_pc = 32'h44; mtvec_in = 32'h1000; m_eie = 1'b1; m_tie = 1'b1;
        ext_irq_m = 1'b1; timer_irq_m = 1'b1;
        n = 0;
        while (exception_pending !== 1'b1 && n < 20) begin neg(1); n++; end
        checks++;
        if (n >= 20 || m_cause !== 32'h8000000B || pc_exc !== 32'h44 || instruction_word !== 30'h0) begin
            failures++; $display("FAIL irq_mei: wait=%0d cause=%h pc=%h instr=%h want 8000000b/44/0",
                                 n, m_cause, pc_exc, instruction_word);
        end
        m_eie = 1'b0;
        neg(2);
`ifdef TRAP_VECTORED_EN
        want = 32'h102C;
`else
        want = 32'h1000;
`endif
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== want) begin
            failures++; $display("FAIL irq_mei_redirect: rv=%b rpc=%h want 1/%h", redirect_valid, redirect_pc, want);
        end
        n = 0;
        while (exception_pending !== 1'b1 && n < 20) begin neg(1); n++; end
        checks++;
        if (n >= 20 || m_cause !== 32'h80000007 || pc_exc !== 32'h44) begin
            failures++; $display("FAIL irq_mti: wait=%0d cause=%h pc=%h want 80000007/44", n, m_cause, pc_exc);
        end
        m_tie = 1'b0; ext_irq_m = 1'b0; timer_irq_m = 1'b0;
        neg(2);
`ifdef TRAP_VECTORED_EN
        want = 32'h101C;
`else
        want = 32'h1000;
`endif
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== want) begin
            failures++; $display("FAIL irq_mti_redirect: rv=%b rpc=%h want 1/%h", redirect_valid, redirect_pc, want);
        end
        neg(SS + 2);
    endtask

    task automatic test_exc_over_irq();
        stall = 1'b1; ext_irq_m = 1'b1; m_eie = 1'b1;
        neg(SS + 1);
        exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h300; stall = 1'b0;
        neg(1);
        stall = 1'b1; exc_valid = 1'b0; ext_irq_m = 1'b0;
        checks++;
        if (exception_pending !== 1'b1 || m_cause[31] !== 1'b0 || m_cause !== 32'h5) begin
            failures++; $display("FAIL exc_over_irq: pend=%b cause=%h want 1/00000005", exception_pending, m_cause);
        end
        neg(SS + 3);
        m_eie = 1'b0; stall = 1'b0;
    endtask

    task automatic test_stall();
        logic seen;
        stall = 1'b1; ext_irq_s = 1'b1; s_eie = 1'b1; irq_pc = 32'h58;
        seen = 1'b0;
        for (int i = 0; i < SS + 4; i++) begin
            neg(1);
            if (exception_pending !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL stall_block: pending seen=%b want 0", seen);
        end
        stall = 1'b0;
        neg(1);
        stall = 1'b1; s_eie = 1'b0; ext_irq_s = 1'b0;
        checks++;
        if (exception_pending !== 1'b1 || m_cause !== 32'h80000009 || pc_exc !== 32'h58) begin
            failures++; $display("FAIL stall_release: pend=%b cause=%h pc=%h want 1/80000009/58",
                                 exception_pending, m_cause, pc_exc);
        end
        neg(SS + 3);
        stall = 1'b0;
    endtask

    task automatic test_reset_in_flush();
        logic seen;
        ext_irq_m = 1'b1;
        mtvec_in = 32'h200;
        neg(SS + 1);
        exc_valid = 1'b1; exc_code = 5'd3; exc_pc = 32'h40;
        neg(1);
        exc_valid = 1'b0;
        neg(1);
        checks++;
        if (ctl !== 6'b000110) begin
            failures++; $display("FAIL rst_pre_flush: ctl=%b want 000110", ctl);
        end
        #1 nrst = 1'b0;
        #1;
        checks++;
        if (ctl !== 6'b0 || redirect_pc !== 32'h0 || m_cause !== 32'h0 || m_interrupt !== 1'b0) begin
            failures++; $display("FAIL rst_in_flush: ctl=%b rpc=%h cause=%h mint=%b want all 0",
                                 ctl, redirect_pc, m_cause, m_interrupt);
        end
        ext_irq_m = 1'b0; stall = 1'b1;
        neg(1);
        nrst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            neg(1);
            if (redirect_valid !== 1'b0 || stall_req !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL rst_no_redirect: activity seen=%b want 0", seen);
        end
        stall = 1'b0;
    endtask

    task automatic test_random(input int iters);
        int          kind;
        logic [4:0]  code;
        logic [31:0] e_cause, e_pc, e_tgt;
        logic [29:0] e_instr;
        logic [5:0]  e_ctl;
        for (int it = 0; it < iters; it++) begin
            stall = 1'b1; exc_valid = 1'b0; mret_valid = 1'b0; sret_valid = 1'b0;
            ext_irq_m = 1'($urandom); ext_irq_s = 1'($urandom);
            timer_irq_m = 1'($urandom); timer_irq_s = 1'($urandom);
            m_eie = 1'($urandom); m_tie = 1'($urandom); s_eie = 1'($urandom); s_tie = 1'($urandom);
            neg(SS + 1);
            exc_valid  = ($urandom_range(0, 3) == 0);
            mret_valid = ($urandom_range(0, 4) == 0);
            sret_valid = ($urandom_range(0, 4) == 0);
            exc_code = 5'($urandom); exc_pc = $urandom; exc_instr = 30'($urandom);
            irq_pc = $urandom; mtvec_in = $urandom; mepc_in = $urandom; sepc_in = $urandom;
            stall = 1'b0;
            kind = 0; code = '0;
            if (exc_valid)                      kind = 1;
            else if (mret_valid)                kind = 2;
            else if (sret_valid)                kind = 3;
            else if (ext_irq_m && m_eie)   begin kind = 4; code = 5'd11; end
            else if (timer_irq_m && m_tie) begin kind = 4; code = 5'd7;  end
            else if (ext_irq_s && s_eie)   begin kind = 4; code = 5'd9;  end
            else if (timer_irq_s && s_tie) begin kind = 4; code = 5'd5;  end
            e_cause = 32'h0; e_pc = 32'h0; e_instr = 30'h0;
            e_ctl = 6'b100110;
            case (kind)
                1: begin e_cause = {27'b0, exc_code}; e_pc = exc_pc; e_instr = exc_instr; end
                2: e_ctl = 6'b110110;
                3: e_ctl = 6'b101110;
                4: begin e_cause = 32'h80000000 + {27'b0, code}; e_pc = irq_pc; end
                default: e_ctl = 6'b0;
            endcase
            neg(1);
            stall = 1'b1; exc_valid = 1'b0; mret_valid = 1'b0; sret_valid = 1'b0;
            m_eie = 1'($urandom); m_tie = 1'($urandom);
            checks++;
            if (ctl !== e_ctl || m_cause !== e_cause || pc_exc !== e_pc || instruction_word !== e_instr) begin
                failures++; $display("FAIL rnd_signal[%0d]: ctl=%b cause=%h pc=%h instr=%h want %b/%h/%h/%h",
                                     it, ctl, m_cause, pc_exc, instruction_word, e_ctl, e_cause, e_pc, e_instr);
            end
            if (kind == 0) continue;
            neg(1);
            mtvec_in = $urandom; mepc_in = $urandom; sepc_in = $urandom;
            checks++;
            if (ctl !== 6'b000110) begin
                failures++; $display("FAIL rnd_flush[%0d]: ctl=%b want 000110", it, ctl);
            end
            neg(1);
            e_tgt = mtvec_in;
            if (kind == 2) e_tgt = mepc_in;
            else if (kind == 3) e_tgt = sepc_in;
`ifdef TRAP_VECTORED_EN
            else if (kind == 4) e_tgt = mtvec_in + 32'(code) * 32'd4;
`endif
            e_tgt[1:0] = 2'b00;
            checks++;
            if (ctl !== 6'b000011 || redirect_pc !== e_tgt) begin
                failures++; $display("FAIL rnd_redirect[%0d]: ctl=%b rpc=%h want 000011/%h",
                                     it, ctl, redirect_pc, e_tgt);
            end
            neg(1);
            checks++;
            if (ctl !== 6'b0) begin
                failures++; $display("FAIL rnd_idle[%0d]: ctl=%b want 000000", it, ctl);
            end
        end
        clear_inputs();
        neg(SS + 1);
    endtask

    initial begin
        test_reset();
        test_sync_latency();
        test_exception();
        test_mret();
        test_irq_priority();
        test_exc_over_irq();
        test_stall();
        test_reset_in_flush();
        test_random(80);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
